// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- iterative radix-2 restoring divider with fixed latency.
//
// Operands are taken through an input valid/ready handshake. The division
// then runs exactly WIDTH iterations, whatever the data is. The result is
// offered through an output valid/ready handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds valid and
// its data stable until that transfer. in_ready is high only in IDLE.
// out_valid is high only in DONE. Accepting new operands never overlaps
// the output handshake, so the minimum issue interval is WIDTH+2 cycles.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   synchronous active-low reset
//   in_valid     in   operand pair valid
//   in_ready     out  block can accept operands (registered)
//   in0          in   dividend [WIDTH]
//   in1          in   divisor  [WIDTH]
//   out_valid    out  result valid
//   out_ready    in   consumer accepts result
//   quot         out  quotient  [WIDTH]
//   rem          out  remainder [WIDTH]
//   div_by_zero  out  divisor was zero (qualified by out_valid)
//
// Optional feature: define DIV_SIGNED_EN for two's-complement operands.
// Magnitudes are divided and the signs are restored when the result is
// loaded. The quotient truncates toward zero and the remainder follows
// the sign of the dividend. When the macro is undefined, the block divides
// unsigned numbers only and contains no sign logic.
//
// FSM state is kept in r_state (type state_t), so assertions can bind to it.
// -----------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem_p;   // partial remainder, one bit wider than WIDTH
    logic [WIDTH-1:0] r_dvd;     // dividend shifts out at the top, quotient shifts in at the bottom
    logic [WIDTH-1:0] r_dvs;
    logic             r_dz;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_div_by_zero;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_q_bit;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;
    logic [WIDTH-1:0] w_dvd_load;
    logic [WIDTH-1:0] w_dvs_load;
    logic [WIDTH-1:0] w_quot_u;
    logic [WIDTH-1:0] w_rem_u;
    logic [WIDTH-1:0] w_quot_fin;
    logic [WIDTH-1:0] w_rem_fin;

    assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_ready;
    // The final iteration happens on the edge that moves the counter from 1 to 0.
    assign w_last   = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));

    // One restoring step. The trial subtraction is one bit wider than the
    // shifted remainder, so its MSB is the borrow.
    assign w_shift   = {r_rem_p, r_dvd[WIDTH-1]};
    assign w_trial   = w_shift - {2'b00, r_dvs};
    assign w_q_bit   = ~w_trial[WIDTH+1];
    assign w_rem_nxt = w_q_bit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
    assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_q_bit};

    // Magnitude result, valid on the last iteration. With a zero divisor
    // every trial succeeds, so the quotient is all ones and the remainder
    // equals the dividend.
    assign w_quot_u = w_dvd_nxt;
    assign w_rem_u  = w_rem_nxt[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_load = in0[WIDTH-1] ? -in0 : in0;
    assign w_dvs_load = in1[WIDTH-1] ? -in1 : in1;
    // MIN/-1 needs no special case: the magnitude 2^(WIDTH-1) with a
    // positive sign reads back as MIN.
    assign w_quot_fin = r_dz ? '1 : (r_neg_q ? -w_quot_u : w_quot_u);
    assign w_rem_fin  = r_neg_r ? -w_rem_u : w_rem_u;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= in0[WIDTH-1] ^ in1[WIDTH-1];
            r_neg_r <= in0[WIDTH-1];
        end
    end
`else
    assign w_dvd_load = in0;
    assign w_dvs_load = in1;
    assign w_quot_fin = w_quot_u;
    assign w_rem_fin  = w_rem_u;
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt         <= '0;
            r_rem_p       <= '0;
            r_dvd         <= '0;
            r_dvs         <= '0;
            r_dz          <= 1'b0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_quot        <= '0;
            r_rem         <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            // Registered so that in_ready stays low during reset and rises
            // on the first edge after reset is released.
            r_in_ready <= (w_state_nxt == ST_IDLE);

            if (w_accept) begin
                r_dvd   <= w_dvd_load;
                r_dvs   <= w_dvs_load;
                r_rem_p <= '0;
                r_cnt   <= CNT_W'(WIDTH);
                r_dz    <= (in1 == '0);
            end else if (r_state == ST_BUSY) begin
                r_rem_p <= w_rem_nxt;
                r_dvd   <= w_dvd_nxt;
                r_cnt   <= r_cnt - CNT_W'(1);
            end

            if (w_last) begin
                r_out_valid   <= 1'b1;
                r_quot        <= w_quot_fin;
                r_rem         <= w_rem_fin;
                r_div_by_zero <= r_dz;
            end else if ((r_state == ST_DONE) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quot        = r_quot;
    assign rem         = r_rem;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_div_iter.sv
`timescale 1ns/1ps
module tb_div_iter;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------- 8-bit DUT
  logic       in_valid8, in_ready8, out_valid8, out_ready8, dz8;
  logic [7:0] in0_8, in1_8, quot8, rem8;

  div_iter #(.WIDTH(8)) u_div8 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in0(in0_8), .in1(in1_8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .quot(quot8), .rem(rem8), .div_by_zero(dz8)
  );

  // ---------------------------------------------------------------- 32-bit DUT
  logic        in_valid32, in_ready32, out_valid32, out_ready32, dz32;
  logic [31:0] in0_32, in1_32, quot32, rem32;

  div_iter #(.WIDTH(32)) u_div32 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .in0(in0_32), .in1(in1_32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .quot(quot32), .rem(rem32), .div_by_zero(dz32)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, why);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------- 8-bit driver
  // Issue one operand pair, check latency, result, optional hold, handshake.
  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input logic edz,
                      input int hold);
    int  e0;
    int  g;
    bit  seen;
    g = 0;
    while (!in_ready8 && g < 50) begin step(); g++; end
    if (!in_ready8) begin fail_now({name, "_ready"}, "in_ready never rose"); return; end
    in0_8 = a; in1_8 = b; in_valid8 = 1'b1;
    step();
    e0 = cyc;
    in_valid8 = 1'b0;
    in0_8 = ~a; in1_8 = ~b;   // must be ignored while busy
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid8) seen = 1'b1;
      else step();
    end
    if (!seen) begin fail_now({name, "_timeout"}, "out_valid never rose"); return; end
    chk({name, "_latency"}, 96'(cyc - e0), 96'd8);
    chk({name, "_quot"}, 96'(quot8), 96'(eq));
    chk({name, "_rem"}, 96'(rem8), 96'(er));
    chk({name, "_dz"}, 96'(dz8), 96'(edz));
    chk({name, "_in_ready_busy"}, 96'(in_ready8), 96'd0);
    for (int h = 0; h < hold; h++) begin
      in0_8 = 8'(h * 37); in1_8 = 8'(h + 1);
      step();
      chk({name, "_hold_valid"}, 96'(out_valid8), 96'd1);
      chk({name, "_hold_quot"}, 96'(quot8), 96'(eq));
      chk({name, "_hold_rem"}, 96'(rem8), 96'(er));
      chk({name, "_hold_in_ready"}, 96'(in_ready8), 96'd0);
    end
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    chk({name, "_valid_drop"}, 96'(out_valid8), 96'd0);
    chk({name, "_in_ready_back"}, 96'(in_ready8), 96'd1);
  endtask

  // ---------------------------------------------------------------- 32-bit model
  function automatic logic [64:0] ref32(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
`ifdef DIV_SIGNED_EN
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000, 32'd0};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
`else
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    q = a / b;
    r = a % b;
`endif
    return {1'b0, q, r};
  endfunction

  task automatic gen32();
    int k;
    k = $urandom_range(0, 9);
    in0_32 = $urandom();
    case (k)
      0:       in1_32 = 32'd0;
      1:       begin in0_32 = 32'h8000_0000; in1_32 = 32'hFFFF_FFFF; end
      2:       begin in0_32 = 32'hFFFF_FFFF; in1_32 = $urandom_range(1, 15); end
      3, 4:    in1_32 = $urandom_range(1, 1000);
      5:       in1_32 = in0_32 + 32'd1;
      default: in1_32 = $urandom();
    endcase
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[10];

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main
  initial begin
    bit          seen;
    bit          acc;
    int          n_acc;
    int          n_done;
    int          last_acc;
    int          guard;
    logic [64:0] e;

`ifdef DIV_SIGNED_EN
    vecs[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0};  // -7/2
    vecs[1] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};  // MIN/-1 overflow
    vecs[2] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0};  // 7/-2
    vecs[3] = '{8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0};  // -7/-2
    vecs[4] = '{8'd100, 8'd7, 8'd14, 8'd2, 1'b0};
    vecs[5] = '{8'h85, 8'h00, 8'hFF, 8'h85, 1'b1};  // -123/0
    vecs[6] = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0};  // MIN/1
    vecs[7] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0};  // 127/MIN
    vecs[8] = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};  // 0/0
    vecs[9] = '{8'hFF, 8'h7F, 8'h00, 8'hFF, 1'b0};  // -1/127
`else
    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[1] = '{8'd255, 8'd0,   8'hFF,  8'd255, 1'b1};
    vecs[2] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[3] = '{8'd5,   8'd200, 8'd0,   8'd5,   1'b0};
    vecs[4] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[6] = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0};
    vecs[7] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vecs[8] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
    vecs[9] = '{8'd171, 8'd13,  8'd13,  8'd2,   1'b0};
`endif

    reset_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; in0_8 = '0; in1_8 = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; in0_32 = '0; in1_32 = '0;

    // reset state
    step(); step();
    chk("rst_in_ready", 96'(in_ready8), 96'd0);
    chk("rst_out_valid", 96'(out_valid8), 96'd0);
    chk("rst_quot", 96'(quot8), 96'd0);
    chk("rst_rem", 96'(rem8), 96'd0);
    chk("rst_dz", 96'(dz8), 96'd0);
    chk("rst_in_ready32", 96'(in_ready32), 96'd0);
    reset_n = 1'b1;
    step();
    chk("rel_in_ready", 96'(in_ready8), 96'd1);
    chk("rel_in_ready32", 96'(in_ready32), 96'd1);

    // out_ready outside DONE must do nothing
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    chk("idle_out_ready_valid", 96'(out_valid8), 96'd0);
    chk("idle_out_ready_in_ready", 96'(in_ready8), 96'd1);

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 0);
    end

    // backpressure: result held 5 cycles
    run8("hold", 8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 5);

    // reset in the middle of BUSY aborts the operation
    in0_8 = 8'd50; in1_8 = 8'd5; in_valid8 = 1'b1;
    step();                       // E0
    in_valid8 = 1'b0;
    step(); step(); step();       // up to E0+3
    reset_n = 1'b0;
    step();                       // E0+4 under reset
    chk("abort_in_ready", 96'(in_ready8), 96'd0);
    chk("abort_out_valid", 96'(out_valid8), 96'd0);
    chk("abort_quot", 96'(quot8), 96'd0);
    chk("abort_rem", 96'(rem8), 96'd0);
    chk("abort_dz", 96'(dz8), 96'd0);
    reset_n = 1'b1;
    step();
    chk("abort_in_ready_back", 96'(in_ready8), 96'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid8) seen = 1'b1;
      step();
    end
    chk("abort_no_valid", 96'(seen), 96'd0);
    run8("after_abort", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 0);

    // 32-bit back-to-back stream, in_valid and out_ready held high
    n_acc = 0; n_done = 0; last_acc = 0; guard = 0;
    gen32();
    in_valid32 = 1'b1;
    out_ready32 = 1'b1;
    while (n_done < 1000 && guard < 40000) begin
      acc = in_ready32 && in_valid32;
      if (acc) begin
        exp_q.push_back(ref32(in0_32, in1_32));
        if (n_acc > 0) chk("b2b_interval", 96'(cyc - last_acc), 96'd34);
        last_acc = cyc;
        n_acc++;
      end
      if (out_valid32) begin
        if (exp_q.size() == 0) begin
          fail_now("b2b_unexpected", "result with no pending operands");
        end else begin
          e = exp_q.pop_front();
          chk("b2b_result", 96'({dz32, quot32, rem32}), 96'(e));
        end
        n_done++;
      end
      step();
      guard++;
      if (acc) begin
        if (n_acc >= 1000) in_valid32 = 1'b0;
        else gen32();
      end
    end
    if (n_done < 1000) fail_now("b2b_timeout", $sformatf("only %0d results", n_done));
    in_valid32 = 1'b0;
    out_ready32 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
